// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_sign_adj.sv
// Conditional two's-complement negate: abs() of operands when neg_i is the sign bit,
// or sign restoration of the result.
module mul_sign_adj #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] data_i,
  input  logic             neg_i,
  output logic [Width-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (neg_i) begin
      data_o = ~data_i + Width'(1);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH add steps over operand magnitudes, then one
// cycle to restore the sign, with valid/ready handshakes on both sides.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  mul_state_e       state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q;
  logic [PW-1:0]    product_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic             sign_mode;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    res_adj;

  always_comb begin
    sign_mode = SIGNED_EN && is_signed;
    a_neg     = sign_mode && a[WIDTH-1];
    b_neg     = sign_mode && b[WIDTH-1];
    addend    = mplier_q[0] ? mcand_q : '0;
  end

  // A magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  mul_sign_adj #(
    .Width (WIDTH)
  ) u_abs_a (
    .data_i (a),
    .neg_i  (a_neg),
    .data_o (a_mag)
  );

  mul_sign_adj #(
    .Width (WIDTH)
  ) u_abs_b (
    .data_i (b),
    .neg_i  (b_neg),
    .data_o (b_mag)
  );

  mul_sign_adj #(
    .Width (PW)
  ) u_res_sign (
    .data_i (acc_q),
    .neg_i  (neg_q),
    .data_o (res_adj)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= {{WIDTH{1'b0}}, a_mag};
            mplier_q   <= b_mag;
            neg_q      <= a_neg ^ b_neg;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CALC;
          end
        end
        CALC: begin
          // WIDTH add steps, then a final cycle that applies the sign to the magnitude.
          if (cnt_q == CntW'(WIDTH)) begin
            product_q   <= res_adj;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q    <= acc_q + addend;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=8: signed and unsigned-only instances.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  logic        u_in_valid;
  logic        u_in_ready;
  logic [7:0]  u_a;
  logic [7:0]  u_b;
  logic        u_is_signed;
  logic        u_out_valid;
  logic        u_out_ready;
  logic [15:0] u_product;
  logic        u_busy;

  int total;
  int bad;
  int lat;

  seq_multiplier #(
    .WIDTH     (8),
    .SIGNED_EN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  seq_multiplier #(
    .WIDTH     (8),
    .SIGNED_EN (1'b0)
  ) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (u_in_valid),
    .in_ready  (u_in_ready),
    .a         (u_a),
    .b         (u_b),
    .is_signed (u_is_signed),
    .out_valid (u_out_valid),
    .out_ready (u_out_ready),
    .product   (u_product),
    .busy      (u_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, scramble the inputs, then expect the result 9 edges later.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input logic [15:0] exp, input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_v;
    is_signed = ts;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    a         = 8'hA5;
    b         = 8'h5A;
    is_signed = ~ts;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd9);
    check({tag, " product"}, 32'(product), 32'(exp));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " drain out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " drain in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    is_signed   = 1'b0;
    out_ready   = 1'b0;
    u_in_valid  = 1'b0;
    u_a         = '0;
    u_b         = '0;
    u_is_signed = 1'b0;
    u_out_ready = 1'b0;
    step();
    step();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst product", 32'(product), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
    check("u255x255 busy in DONE", 32'(busy), 32'd1);
    drain("u255x255");
    check("idle keeps product", 32'(product), 32'hFE01);

    run_op(8'hFD, 8'd5, 1'b1, 16'hFFF1, "s-3x5");
    drain("s-3x5");
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, "s-128x-128");
    drain("s-128x-128");
    run_op(8'h80, 8'h7F, 1'b1, 16'hC080, "s-128x127");
    drain("s-128x127");
    run_op(8'hFD, 8'd5, 1'b0, 16'h04F1, "u253x5");
    drain("u253x5");

    // Backpressure: result must hold while out_ready stays low.
    run_op(8'd12, 8'd11, 1'b0, 16'd132, "hold");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold product", 32'(product), 32'd132);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    drain("hold");

    // Reset pulse mid-calculation aborts the operation.
    a        = 8'd9;
    b        = 8'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort product", 32'(product), 32'd0);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) lat++;
    end
    check("abort no out_valid", 32'(lat), 32'd0);
    run_op(8'd7, 8'd6, 1'b0, 16'd42, "after abort");
    drain("after abort");

    // Back-to-back with in_valid held high across both operations.
    a         = 8'd2;
    b         = 8'd3;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    step();
    a = 8'd0;
    b = 8'd200;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("b2b first latency", 32'(lat), 32'd9);
    check("b2b first product", 32'(product), 32'd6);
    check("b2b busy blocks input", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("b2b in_ready after drain", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b second accepted", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("b2b second latency", 32'(lat), 32'd9);
    check("b2b second product", 32'(product), 32'd0);
    drain("b2b second");

    // Unsigned-only instance ignores is_signed.
    u_a         = 8'hFF;
    u_b         = 8'd2;
    u_is_signed = 1'b1;
    u_in_valid  = 1'b1;
    step();
    u_in_valid = 1'b0;
    lat = 0;
    while (!u_out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("nosign latency", 32'(lat), 32'd9);
    check("nosign product", 32'(u_product), 32'd510);
    u_out_ready = 1'b1;
    step();
    u_out_ready = 1'b0;
    check("nosign drain", 32'(u_in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand width; legal range 2..32.
REQ-002 Parameter SIGNED_EN, default 1, SHALL enable signed mode; when 0, is_signed is ignored and all operations are unsigned.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  operand pair a/b/is_signed is valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  multiplicand.
REQ-008 b  input  WIDTH  multiplier.
REQ-009 is_signed  input  1  1: treat a and b as two's complement; 0: unsigned.
REQ-010 out_valid  output  1  product is valid.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 product  output  2*WIDTH  exact product of the accepted operands.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 in_ready SHALL equal (state == IDLE); no other state accepts input.
REQ-016 Input handshake: on an edge with in_valid && in_ready, latch a, b and the effective sign mode, clear the accumulator and iteration counter, and go IDLE -> CALC.
REQ-017 CALC SHALL perform one shift-add step per cycle over operand magnitudes, for exactly WIDTH cycles, then go to DONE.
REQ-018 out_valid SHALL rise exactly WIDTH+1 rising edges after the accepting edge, so latency is WIDTH+1 cycles.
REQ-019 Signed mode SHALL multiply absolute values, then negate the 2*WIDTH result when the operand signs differ.
REQ-020 product SHALL always be exact and never saturate or overflow; signed (-2^(W-1))*(-2^(W-1)) SHALL equal +2^(2W-2).
REQ-021 In DONE, out_valid=1 and product SHALL hold stable until out_ready=1.
REQ-022 Output handshake: on an edge with out_valid && out_ready, go DONE -> IDLE; in_ready is high on the following cycle.
REQ-023 product SHALL keep its last result while in IDLE; only out_valid qualifies it.
REQ-024 Changes on a, b or is_signed after acceptance SHALL NOT affect the result in flight.
REQ-025 in_valid asserted while busy SHALL be ignored; the upstream source must hold it until in_ready.
REQ-026 Operand 0 SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-027 While rst_n=0 at a rising edge: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, and the accumulator and counter are cleared.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation and discard the result; out_valid is 0 on the cycle after the reset edge.
REQ-029 Reset SHALL override any handshake that occurs on the same edge.

Structure
REQ-030 Package mul_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the counter-width function clog2(WIDTH+1).
REQ-031 One sub-module, mul_sign_adj, SHALL provide the abs/negate logic, parametrised by width, and be instantiated for the operands and for the result.
REQ-032 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-033 Unsigned a=255, b=255 -> product=65025 (0xFE01), out_valid on the 9th edge after acceptance.
REQ-034 Signed a=-3 (0xFD), b=5 -> product=0xFFF1 (-15); signed a=0x80, b=0x80 -> product=0x4000.
REQ-035 Hold out_ready=0 for 5 cycles after out_valid with a=12, b=11 -> product stays 132, in_ready stays 0, and the result drains on the first out_ready=1.
REQ-036 Pulse rst_n=0 for one cycle during CALC -> IDLE on the next cycle, out_valid never asserts, and the next op a=7, b=6 gives 42.
REQ-037 Keep in_valid=1 continuously over two ops (2*3, then 0*200) -> second op accepted only the cycle after the first output handshake; products are 6 and 0.
REQ-038 With SIGNED_EN=0 and is_signed=1, a=0xFF, b=2 -> product=510.
